// File: rtl/request_unit_if.sv
// Purpose: bundles control-unit requests, cache handshakes and unit outputs of request_unit.
// Latency: none, wires only.
// Backpressure: ihit/dhit from the caches are the only stall sources carried here.
interface request_unit_if #(
    parameter int CNT_W = 32
);
    logic             cu_dREN;
    logic             cu_dWEN;
    logic             cu_datomic;
    logic             cu_halt;
    logic [31:0]      cu_dmemaddr;
    logic [31:0]      cu_dmemstore;
    logic             ihit;
    logic             dhit;
    logic             iREN;
    logic             dREN;
    logic             dWEN;
    logic             datomic;
    logic [31:0]      dmemaddr;
    logic [31:0]      dmemstore;
    logic             pc_en;
    logic             commit;
    logic             halt;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Driver side: control unit and caches feeding the request unit.
    modport master (
        output cu_dREN, cu_dWEN, cu_datomic, cu_halt, cu_dmemaddr, cu_dmemstore, ihit, dhit,
        input  iREN, dREN, dWEN, datomic, dmemaddr, dmemstore, pc_en, commit, halt,
               instr_cnt, stall_cnt
    );

    // Request unit side.
    modport slave (
        input  cu_dREN, cu_dWEN, cu_datomic, cu_halt, cu_dmemaddr, cu_dmemstore, ihit, dhit,
        output iREN, dREN, dWEN, datomic, dmemaddr, dmemstore, pc_en, commit, halt,
               instr_cnt, stall_cnt
    );
endinterface

// File: rtl/request_unit.sv
// Purpose: sequences one fetch and at most one data access per instruction; emits pc_en/commit strobes.
// Latency: non-memory instruction commits in its ihit cycle; memory instruction commits in its dhit cycle.
// Backpressure: waits in FETCH for ihit and in DATA for dhit; HALTED is left only through nRST.
module request_unit #(
    parameter int CNT_W = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    request_unit_if.slave bus
);
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_dren;
    logic             r_dwen;
    logic             r_datomic;
    logic [31:0]      r_addr;
    logic [31:0]      r_store;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_latch;
    logic             w_clear;
    logic             w_commit;
    logic             w_stall;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= FETCH;
        else       r_state <= w_next;
    end

    // Next state and strobes; ihit only matters in FETCH, dhit only in DATA, halt wins over a data request.
    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_clear  = 1'b0;
        w_commit = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            FETCH: begin
                if (bus.ihit) begin
                    if (bus.cu_halt) begin
                        w_next = HALTED;
                    end else if (bus.cu_dREN || bus.cu_dWEN) begin
                        w_latch = 1'b1;
                        w_next  = DATA;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.dhit) begin
                    w_commit = 1'b1;
                    w_clear  = 1'b1;
                    w_next   = FETCH;
                end else begin
                    w_stall = 1'b1;
                end
            end
            HALTED:  w_next = HALTED;
            default: w_next = FETCH;
        endcase
    end

    // Capture the data request at the fetch edge so later control-unit changes cannot disturb the access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dren    <= 1'b0;
            r_dwen    <= 1'b0;
            r_datomic <= 1'b0;
            r_addr    <= '0;
            r_store   <= '0;
        end else if (w_latch) begin
            r_dren    <= bus.cu_dREN;
            r_dwen    <= bus.cu_dWEN;
            r_datomic <= bus.cu_datomic;
            r_addr    <= bus.cu_dmemaddr;
            r_store   <= bus.cu_dmemstore;
        end else if (w_clear) begin
            r_dren    <= 1'b0;
            r_dwen    <= 1'b0;
            r_datomic <= 1'b0;
        end
    end

    // Performance counters, free-running with natural wrap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_commit) r_instr_cnt <= r_instr_cnt + 1'b1;
            if (w_stall)  r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Strobes are masked by nRST so nothing fires while reset is held.
    assign bus.iREN      = nRST && (r_state == FETCH);
    assign bus.dREN      = (r_state == DATA) && r_dren;
    assign bus.dWEN      = (r_state == DATA) && r_dwen;
    assign bus.datomic   = (r_state == DATA) && r_datomic;
    assign bus.dmemaddr  = r_addr;
    assign bus.dmemstore = r_store;
    assign bus.pc_en     = nRST && w_commit;
    assign bus.commit    = nRST && w_commit;
    assign bus.halt      = (r_state == HALTED);
    assign bus.instr_cnt = r_instr_cnt;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_request_unit.sv
// Purpose: self-checking bench for request_unit (32-bit and 4-bit counter instances in lockstep).
// Latency: inputs driven on falling edge, outputs sampled 1 time unit later.
// Backpressure: ihit/dhit generated directly by the bench.
module tb_request_unit;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    request_unit_if #(.CNT_W(32)) bus();
    request_unit_if #(.CNT_W(4))  bus4();

    request_unit #(.CNT_W(32)) dut  (.CLK(CLK), .nRST(nRST), .bus(bus));
    request_unit #(.CNT_W(4))  dut4 (.CLK(CLK), .nRST(nRST), .bus(bus4));

    assign bus4.cu_dREN      = bus.cu_dREN;
    assign bus4.cu_dWEN      = bus.cu_dWEN;
    assign bus4.cu_datomic   = bus.cu_datomic;
    assign bus4.cu_halt      = bus.cu_halt;
    assign bus4.cu_dmemaddr  = bus.cu_dmemaddr;
    assign bus4.cu_dmemstore = bus.cu_dmemstore;
    assign bus4.ihit         = bus.ihit;
    assign bus4.dhit         = bus.dhit;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ih, input logic dh, input logic rd, input logic wr,
                         input logic at, input logic hl, input logic [31:0] a, input logic [31:0] s);
        bus.ihit         = ih;
        bus.dhit         = dh;
        bus.cu_dREN      = rd;
        bus.cu_dWEN      = wr;
        bus.cu_datomic   = at;
        bus.cu_halt      = hl;
        bus.cu_dmemaddr  = a;
        bus.cu_dmemstore = s;
        #1;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk_o(input string t, input logic ei, input logic ed, input logic ew,
                         input logic ea, input logic ep, input logic eh);
        chk({t, " iREN"},    32'(bus.iREN),    32'(ei));
        chk({t, " dREN"},    32'(bus.dREN),    32'(ed));
        chk({t, " dWEN"},    32'(bus.dWEN),    32'(ew));
        chk({t, " datomic"}, 32'(bus.datomic), 32'(ea));
        chk({t, " pc_en"},   32'(bus.pc_en),   32'(ep));
        chk({t, " commit"},  32'(bus.commit),  32'(ep));
        chk({t, " halt"},    32'(bus.halt),    32'(eh));
    endtask

    task automatic chk_cnt(input string t, input int ic, input int sc);
        chk({t, " instr_cnt"},   bus.instr_cnt,          32'(ic));
        chk({t, " stall_cnt"},   bus.stall_cnt,          32'(sc));
        chk({t, " instr_cnt4"},  32'(bus4.instr_cnt),    32'(ic & 15));
        chk({t, " stall_cnt4"},  32'(bus4.stall_cnt),    32'(sc & 15));
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        tick();
        nRST = 1'b1;
        #1;
    endtask

    // Illegal simultaneous read and write must never reach the cache.
    always @(negedge CLK) begin
        if (nRST) begin
            n_cmp++;
            if (bus.dREN && bus.dWEN) begin
                n_bad++;
                $display("FAIL rd_wr_excl: dREN=1 dWEN=1 at %0t", $time);
            end
        end
    end

    typedef struct {
        logic ih, dh, rd, wr, at, hl;
        logic [31:0] a, s;
        logic ei, ed, ew, ea, ep, eh;
        logic [31:0] xa, xs;
        int ic, sc;
    } vec_t;

    function automatic vec_t v(input logic ih, input logic dh, input logic rd, input logic wr,
                               input logic at, input logic hl, input logic [31:0] a, input logic [31:0] s,
                               input logic ei, input logic ed, input logic ew, input logic ea,
                               input logic ep, input logic eh, input logic [31:0] xa,
                               input logic [31:0] xs, input int ic, input int sc);
        vec_t r;
        r.ih = ih; r.dh = dh; r.rd = rd; r.wr = wr; r.at = at; r.hl = hl; r.a = a; r.s = s;
        r.ei = ei; r.ed = ed; r.ew = ew; r.ea = ea; r.ep = ep; r.eh = eh; r.xa = xa; r.xs = xs;
        r.ic = ic; r.sc = sc;
        return r;
    endfunction

    vec_t tbl[18];

    initial begin
        int m_ic;
        int m_sc;
        //            ih dh rd wr at hl addr          store         ei ed ew ea ep eh xaddr         xstore       ic sc
        tbl[0]  = v(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        0, 0);
        tbl[1]  = v(1, 0, 0, 0, 0, 0, 32'h4,        32'h0,        1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 0);
        tbl[2]  = v(1, 0, 0, 0, 0, 0, 32'h8,        32'h0,        1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        2, 0);
        tbl[3]  = v(1, 0, 0, 0, 0, 0, 32'hC,        32'h0,        1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        3, 0);
        tbl[4]  = v(1, 0, 1, 0, 1, 0, 32'h100,      32'h55,       1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        4, 0);
        tbl[5]  = v(1, 0, 0, 1, 0, 0, 32'h999,      32'h66,       0, 1, 0, 1, 0, 0, 32'h100,      32'h55,       4, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 0, 1, 0, 0, 32'h100,      32'h55,       4, 1);
        tbl[7]  = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 1, 1, 0, 32'h100,      32'h55,       4, 2);
        tbl[8]  = v(1, 0, 0, 1, 0, 0, 32'h200,      32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        5, 2);
        tbl[9]  = v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 0, 0, 32'h200,      32'hDEADBEEF, 5, 2);
        tbl[10] = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 1, 0, 32'h200,      32'hDEADBEEF, 5, 3);
        tbl[11] = v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        6, 3);
        tbl[12] = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        6, 3);
        tbl[13] = v(1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        6, 3);
        tbl[14] = v(1, 0, 0, 1, 0, 1, 32'h300,      32'h1,        1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        7, 3);
        tbl[15] = v(1, 1, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        7, 3);
        tbl[16] = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        7, 3);
        tbl[17] = v(1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        7, 3);

        // Reset values while nRST is held low.
        drive(1, 1, 1, 1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk_o("reset", 0, 0, 0, 0, 0, 0);
        chk_cnt("reset", 0, 0);
        chk("reset dmemaddr",  bus.dmemaddr,  32'h0);
        chk("reset dmemstore", bus.dmemstore, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        nRST = 1'b1;
        #1;
        chk("release iREN", 32'(bus.iREN), 32'h1);

        // Directed table: ALU run, load, store with data change, stray dhit, ihit+dhit, halt.
        for (int i = 0; i < 18; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].ih, tbl[i].dh, tbl[i].rd, tbl[i].wr, tbl[i].at, tbl[i].hl, tbl[i].a, tbl[i].s);
            chk_o(t, tbl[i].ei, tbl[i].ed, tbl[i].ew, tbl[i].ea, tbl[i].ep, tbl[i].eh);
            chk_cnt(t, tbl[i].ic, tbl[i].sc);
            if (tbl[i].ed || tbl[i].ew) begin
                chk({t, " dmemaddr"},  bus.dmemaddr,  tbl[i].xa);
                chk({t, " dmemstore"}, bus.dmemstore, tbl[i].xs);
            end
            tick();
        end

        // Reset asserted between edges while a load is outstanding.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        drive(1, 0, 1, 0, 0, 0, 32'hABC, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        chk("middata dREN",  32'(bus.dREN), 32'h1);
        chk_cnt("middata", 1, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk_o("rst_mid", 0, 0, 0, 0, 0, 0);
        chk("rst_mid dmemaddr", bus.dmemaddr, 32'h0);
        chk_cnt("rst_mid", 0, 0);
        tick();
        nRST = 1'b1;
        #1;
        chk_o("rst_rel", 1, 0, 0, 0, 0, 0);

        // Counter wrap on the 4-bit instance, then a stray dhit in FETCH.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0, 0, 0, 0, 32'(i), 32'h0);
            chk("wrap pc_en", 32'(bus.pc_en), 32'h1);
            tick();
        end
        drive(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        chk_cnt("wrap", 17, 0);
        chk_o("stray_dhit", 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_o("after_stray", 1, 0, 0, 0, 0, 0);
        chk_cnt("after_stray", 17, 0);

        // Random instruction stream against a transaction-level model.
        do_reset();
        m_ic = 0;
        m_sc = 0;
        for (int n = 0; n < 300; n++) begin
            int gap;
            int kind;
            int k;
            logic rd, wr, at;
            logic [31:0] a, s;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom, $urandom);
                chk_o("rnd_idle", 1, 0, 0, 0, 0, 0);
                tick();
            end
            kind = $urandom_range(0, 3);
            rd = (kind == 1) || ((kind == 3) && 1'($urandom));
            wr = (kind == 2) || ((kind == 3) && !rd);
            at = (kind == 3);
            a  = $urandom;
            s  = $urandom;
            drive(1, 1'($urandom), rd, wr, at, 0, a, s);
            chk_o("rnd_fetch", 1, 0, 0, 0, (kind == 0), 0);
            chk_cnt("rnd_fetch", m_ic, m_sc);
            tick();
            if (kind != 0) begin
                k = $urandom_range(1, 4);
                for (int j = 1; j <= k; j++) begin
                    drive(1'($urandom), (j == k), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), $urandom, $urandom);
                    chk_o("rnd_data", 0, rd, wr, at, (j == k), 0);
                    chk("rnd_data dmemaddr",  bus.dmemaddr,  a);
                    chk("rnd_data dmemstore", bus.dmemstore, s);
                    tick();
                    if (j != k) m_sc++;
                end
            end
            m_ic++;
        end
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_cnt("rnd_end", m_ic, m_sc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
